// File: rtl/mrav_pkg.sv
// Shared MRAV bus constants and the arbiter's state type.
package mrav_pkg;

    localparam int MRAV_ADDR_WIDTH  = 16;
    localparam int MRAV_DATA_WIDTH  = 16;
    localparam int MRAV_ARB_TIMEOUT = 255;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Counter only has to reach cycles-1, so clog2(cycles) bits are enough.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mrav_bus_arbiter_if.sv
// One MRAV memory-bus connection: level requests out, done pulses and read data back.
interface mrav_bus_arbiter_if
    import mrav_pkg::*;
#(
    parameter int ADDR_WIDTH = MRAV_ADDR_WIDTH,
    parameter int DATA_WIDTH = MRAV_DATA_WIDTH
) ();

    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  read_done;
    logic                  write_done;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output read, write, addr, wdata,
        input  read_done, write_done, rdata
    );

    modport slave (
        input  read, write, addr, wdata,
        output read_done, write_done, rdata
    );

endinterface

// File: rtl/mrav_arb_watchdog.sv
// Counts granted cycles without a memory done; expire marks the last allowed cycle.
module mrav_arb_watchdog
    import mrav_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MRAV_ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (clear) begin
            tmo_cnt_reg <= '0;
        end else if (enable && !expire) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign expire = enable && (tmo_cnt_reg == CNT_LAST);

endmodule

// File: rtl/mrav_bus_arbiter.sv
// Two-master round-robin arbiter for the MRAV memory port, one transaction per grant,
// with a watchdog that forces completion when memory never answers.
module mrav_bus_arbiter
    import mrav_pkg::*;
#(
    parameter int ADDR_WIDTH     = MRAV_ADDR_WIDTH,
    parameter int DATA_WIDTH     = MRAV_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = MRAV_ARB_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    mrav_bus_arbiter_if.slave    m0,
    mrav_bus_arbiter_if.slave    m1,
    mrav_bus_arbiter_if.master   mem,
    output logic [1:0]           timeout_err
);

    logic [1:0]            req_rd;
    logic [1:0]            req_wr;
    logic [1:0]            req;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];

    arb_state_t state_reg;
    logic       grant_id_reg;
    logic       prio_reg;
    logic       is_write_reg;
    logic [1:0] timeout_err_reg;

    logic granted;
    logic grant_pick;
    logic idle_grant;
    logic mem_done;
    logic expire;
    logic complete;

    logic [1:0]            rd_done;
    logic [1:0]            wr_done;
    logic [DATA_WIDTH-1:0] rdata_out [2];

    assign req_rd       = {m1.read, m0.read};
    assign req_wr       = {m1.write, m0.write};
    assign req          = req_rd | req_wr;
    assign req_addr[0]  = m0.addr;
    assign req_addr[1]  = m1.addr;
    assign req_wdata[0] = m0.wdata;
    assign req_wdata[1] = m1.wdata;

    assign granted    = (state_reg == ARB_GRANT);
    assign grant_pick = (req == 2'b11) ? prio_reg : req[1];
    assign idle_grant = (state_reg == ARB_IDLE) && (|req);
    // Only a done of the type that was issued counts; anything else is noise.
    assign mem_done   = granted && (is_write_reg ? mem.write_done : mem.read_done);
    assign complete   = mem_done || expire;

    mrav_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (idle_grant),
        .enable (granted && !mem_done),
        .expire (expire)
    );

    // Every completion returns to ARB_IDLE for one cycle so the master can
    // retire its request before it is sampled again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ARB_IDLE;
            grant_id_reg    <= 1'b0;
            prio_reg        <= 1'b0;
            is_write_reg    <= 1'b0;
            timeout_err_reg <= 2'b00;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (|req) begin
                        grant_id_reg <= grant_pick;
                        is_write_reg <= req_wr[grant_pick] & ~req_rd[grant_pick];
                        state_reg    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (complete) begin
                        prio_reg  <= ~grant_id_reg;
                        state_reg <= ARB_IDLE;
                        if (!mem_done) begin
                            timeout_err_reg[grant_id_reg] <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign mem.read    = granted & ~is_write_reg;
    assign mem.write   = granted & is_write_reg;
    assign mem.addr    = granted ? req_addr[grant_id_reg]  : '0;
    assign mem.wdata   = granted ? req_wdata[grant_id_reg] : '0;
    assign timeout_err = timeout_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic mine;
            assign mine          = granted && (grant_id_reg == 1'(gi));
            assign rd_done[gi]   = mine && !is_write_reg && complete;
            assign wr_done[gi]   = mine && is_write_reg && complete;
            // A forced completion returns zero rather than whatever is on mem_rdata.
            assign rdata_out[gi] = (mine && !is_write_reg && mem_done) ? mem.rdata : '0;
        end
    endgenerate

    assign m0.read_done  = rd_done[0];
    assign m0.write_done = wr_done[0];
    assign m0.rdata      = rdata_out[0];
    assign m1.read_done  = rd_done[1];
    assign m1.write_done = wr_done[1];
    assign m1.rdata      = rdata_out[1];

endmodule

// File: tb/tb_mrav_bus_arbiter.sv
// Directed and randomized bench for mrav_bus_arbiter against a cycle-level reference model.
module tb_mrav_bus_arbiter;
    import mrav_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] timeout_err;

    mrav_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
    mrav_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
    mrav_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    mrav_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .mem         (mem_bus),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner is -1 when nobody holds the port, age counts granted cycles.
    int       owner = -1;
    int       pref  = 0;
    bit       own_wr = 1'b0;
    int       age   = 0;
    bit [1:0] terr  = 2'b00;
    bit [1:0] seen_rd_done = 2'b00;
    bit [1:0] seen_wr_done = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_rd(input int m);
        return (m == 1) ? m1_bus.read : m0_bus.read;
    endfunction
    function automatic logic get_wr(input int m);
        return (m == 1) ? m1_bus.write : m0_bus.write;
    endfunction
    function automatic logic [AW-1:0] get_addr(input int m);
        return (m == 1) ? m1_bus.addr : m0_bus.addr;
    endfunction
    function automatic logic [DW-1:0] get_wdata(input int m);
        return (m == 1) ? m1_bus.wdata : m0_bus.wdata;
    endfunction

    task automatic set_master(input int m, input bit rd, input bit wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 1) begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.addr = a; m1_bus.wdata = d;
        end else begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.addr = a; m0_bus.wdata = d;
        end
    endtask

    task automatic set_mem(input bit rdd, input bit wrd, input logic [DW-1:0] rd);
        mem_bus.read_done = rdd; mem_bus.write_done = wrd; mem_bus.rdata = rd;
    endtask

    task automatic model_reset();
        owner = -1; pref = 0; own_wr = 1'b0; age = 0; terr = 2'b00;
        seen_rd_done = 2'b00; seen_wr_done = 2'b00;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_read"},  32'(mem_bus.read),  32'(0));
        chk({tag, "_mem_write"}, 32'(mem_bus.write), 32'(0));
        chk({tag, "_mem_addr"},  32'(mem_bus.addr),  32'(0));
        chk({tag, "_mem_wdata"}, 32'(mem_bus.wdata), 32'(0));
        chk({tag, "_dones"}, 32'({m1_bus.write_done, m1_bus.read_done,
                                  m0_bus.write_done, m0_bus.read_done}), 32'(0));
        chk({tag, "_rdata"}, 32'({m1_bus.rdata, m0_bus.rdata}), 32'(0));
        chk({tag, "_terr"},  32'(timeout_err), 32'(0));
    endtask

    // Called at a falling edge with inputs already applied: checks this cycle's
    // outputs, advances the model across the next rising edge, returns at the next falling edge.
    task automatic step();
        logic          e_mrd, e_mwr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [1:0]    e_rdd, e_wrd;
        logic [DW-1:0] e_rdata [2];
        bit            fin, timed, r0, r1;
        int            nxt;
        #1;
        e_mrd = 1'b0; e_mwr = 1'b0; e_addr = '0; e_wd = '0;
        e_rdd = 2'b00; e_wrd = 2'b00; e_rdata[0] = '0; e_rdata[1] = '0;
        fin = 1'b0; timed = 1'b0;
        if (owner >= 0) begin
            e_mrd  = !own_wr;
            e_mwr  = own_wr;
            e_addr = get_addr(owner);
            e_wd   = get_wdata(owner);
            fin    = own_wr ? mem_bus.write_done : mem_bus.read_done;
            timed  = !fin && (age == TO - 1);
            if (fin || timed) begin
                if (own_wr) e_wrd[owner] = 1'b1;
                else        e_rdd[owner] = 1'b1;
            end
            if (fin && !own_wr) e_rdata[owner] = mem_bus.rdata;
        end
        chk("mem_read",  32'(mem_bus.read),  32'(e_mrd));
        chk("mem_write", 32'(mem_bus.write), 32'(e_mwr));
        chk("mem_addr",  32'(mem_bus.addr),  32'(e_addr));
        chk("mem_wdata", 32'(mem_bus.wdata), 32'(e_wd));
        chk("m0_read_done",  32'(m0_bus.read_done),  32'(e_rdd[0]));
        chk("m0_write_done", 32'(m0_bus.write_done), 32'(e_wrd[0]));
        chk("m1_read_done",  32'(m1_bus.read_done),  32'(e_rdd[1]));
        chk("m1_write_done", 32'(m1_bus.write_done), 32'(e_wrd[1]));
        chk("m0_rdata", 32'(m0_bus.rdata), 32'(e_rdata[0]));
        chk("m1_rdata", 32'(m1_bus.rdata), 32'(e_rdata[1]));
        chk("timeout_err", 32'(timeout_err), 32'(terr));
        seen_rd_done = e_rdd;
        seen_wr_done = e_wrd;
        if (owner < 0) begin
            r0 = get_rd(0) | get_wr(0);
            r1 = get_rd(1) | get_wr(1);
            if (r0 || r1) begin
                nxt    = (r0 && r1) ? pref : (r1 ? 1 : 0);
                owner  = nxt;
                own_wr = get_wr(nxt) && !get_rd(nxt);
                age    = 0;
            end
        end else if (fin || timed) begin
            if (timed) terr[owner] = 1'b1;
            pref  = 1 - owner;
            owner = -1;
        end else begin
            age++;
        end
        @(negedge clk);
    endtask

    initial begin
        int  g;
        int  exp_m;
        int  grants;
        bit  got_done;
        bit  silent;
        bit  active [2];
        int  k;

        set_master(0, 0, 0, '0, '0);
        set_master(1, 0, 0, '0, '0);
        set_mem(0, 0, '0);
        model_reset();

        // Reset state, with a request present so the grant must stay blocked.
        rst = 1'b1;
        set_master(0, 1, 0, 16'h0077, '0);
        @(negedge clk); @(negedge clk);
        check_quiet("reset");
        set_master(0, 0, 0, '0, '0);
        rst = 1'b0;
        step();

        // Single read, memory answers after three granted cycles.
        set_master(0, 1, 0, 16'h0010, '0);
        step();
        chk("sr_latency_mem_read", 32'(mem_bus.read), 32'(1));
        step(); step();
        set_mem(1, 0, 16'hBEEF);
        step();
        chk("sr_done_seen", 32'(seen_rd_done), 32'(2'b01));
        set_mem(0, 0, '0);
        set_master(0, 0, 0, '0, '0);
        step();

        // Write from master 1.
        set_master(1, 0, 1, 16'h0020, 16'h1234);
        step();
        chk("wr_mem_write", 32'(mem_bus.write), 32'(1));
        chk("wr_mem_addr",  32'(mem_bus.addr),  32'(16'h0020));
        chk("wr_mem_wdata", 32'(mem_bus.wdata), 32'(16'h1234));
        step();
        set_mem(0, 1, '0);
        step();
        set_mem(0, 0, '0);
        set_master(1, 0, 0, '0, '0);
        step();

        // Read and write both high: read wins; a write done must be ignored.
        set_master(0, 1, 1, 16'h0030, 16'h5555);
        step();
        chk("rw_mem_read",  32'(mem_bus.read),  32'(1));
        chk("rw_mem_write", 32'(mem_bus.write), 32'(0));
        set_mem(0, 1, 16'h9999);
        step();
        set_mem(1, 0, 16'h4242);
        step();
        set_mem(0, 0, '0);
        set_master(0, 0, 0, '0, '0);
        step();

        // Contention with an always-ready memory: grants must alternate.
        set_master(0, 1, 0, 16'h0100, '0);
        set_master(1, 1, 0, 16'h0101, '0);
        exp_m  = pref;
        grants = 0;
        for (int i = 0; i < 16; i++) begin
            set_mem(1, 0, 16'($urandom));
            step();
            if (mem_bus.read) begin
                chk("alt_master_addr", 32'(mem_bus.addr), (exp_m == 1) ? 32'h0101 : 32'h0100);
                exp_m  = 1 - exp_m;
                grants++;
            end
        end
        chk("alt_grant_count", 32'(grants), 32'(8));
        set_master(0, 0, 0, '0, '0);
        set_master(1, 0, 0, '0, '0);
        set_mem(0, 0, '0);
        step(); step();

        // Timeout: silent memory, then a late done that must be ignored.
        set_master(0, 1, 0, 16'h0040, '0);
        g        = 0;
        got_done = 1'b0;
        for (int i = 0; i < TO + 10 && !got_done; i++) begin
            if (mem_bus.read) g++;
            step();
            if (seen_rd_done[0]) got_done = 1'b1;
        end
        chk("tmo_done_seen", 32'(got_done), 32'(1));
        chk("tmo_granted_cycles", 32'(g), 32'(TO));
        set_master(0, 0, 0, '0, '0);
        set_mem(1, 0, 16'hDEAD);
        step(); step();
        set_mem(0, 0, '0);
        chk("tmo_err_sticky", 32'(timeout_err), 32'(2'b01));

        // Asynchronous reset in the middle of a master-1 grant.
        set_master(1, 1, 0, 16'h0060, '0);
        step(); step();
        chk("pre_rst_mem_read", 32'(mem_bus.read), 32'(1));
        rst = 1'b1;
        set_master(0, 1, 0, 16'h0050, '0);
        set_mem(1, 0, 16'h1111);
        #1;
        check_quiet("arst");
        @(negedge clk); @(negedge clk);
        check_quiet("rst_hold");
        set_mem(0, 0, '0);
        rst = 1'b0;
        model_reset();
        step();
        chk("post_rst_first_grant", 32'(mem_bus.addr), 32'(16'h0050));
        set_mem(1, 0, 16'hCAFE);
        step();
        set_master(0, 0, 0, '0, '0);
        set_master(1, 0, 0, '0, '0);
        set_mem(0, 0, '0);
        step(); step();

        // Randomized traffic with stray dones, silent stretches and dropped requests.
        silent    = 1'b0;
        active[0] = 1'b0;
        active[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (seen_rd_done[m] || seen_wr_done[m]) begin
                    active[m] = 1'b0;
                    set_master(m, 0, 0, '0, '0);
                end
                if (!active[m] && ($urandom % 3 == 0)) begin
                    k = int'($urandom % 3);
                    set_master(m, k != 1, k != 0, 16'($urandom), 16'($urandom));
                    active[m] = 1'b1;
                end else if (active[m] && ($urandom % 64 == 0)) begin
                    set_master(m, 0, 0, '0, '0);
                    active[m] = 1'b0;
                end
            end
            if ($urandom % 40 == 0) silent = !silent;
            set_mem(!silent && ($urandom % 3 == 0), !silent && ($urandom % 3 == 0),
                    16'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
